// File: rtl/adc_capture_ctrl.sv
// Run-level sequencer for the ADC packetizer: frame scheduling, beat/frame counting, stall watchdog.
// Optional macro ADC_CAPTURE_EXT_TRIG_EN makes WAIT_TRIG wait for a rising edge of trig_i.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | no run; waiting for start_i
// ARM        | configuration latched, one settling cycle
// WAIT_TRIG  | waiting for trigger condition before the next frame
// CAPTURE    | capture_en_o high, watching for frame end / stall / abort
// GAP        | programmed idle cycles between frames
// DONE       | one-cycle done_o pulse, then back to IDLE
module adc_capture_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned GAP_WIDTH      = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [31:0]          frame_len_i,
   input  logic [15:0]          num_frames_i,
   input  logic [GAP_WIDTH-1:0] gap_cycles_i,
   input  logic                 trig_i,
   input  logic                 s_tvalid_i,
   input  logic                 s_tready_i,
   input  logic                 s_tlast_i,
   output logic                 capture_en_o,
   output logic [31:0]          length_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 timeout_o,
   output logic                 aborted_o,
   output logic [15:0]          frame_cnt_o,
   output logic [31:0]          beat_cnt_o
);

   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_WAIT_TRIG,
      ST_CAPTURE,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          length_q, length_d;
   logic [15:0]          num_frames_q, num_frames_d;
   logic [GAP_WIDTH-1:0] gap_q, gap_d;
   logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
   logic                 capture_en_q, capture_en_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 timeout_q, timeout_d;
   logic                 aborted_q, aborted_d;
   logic [15:0]          frame_cnt_q, frame_cnt_d;
   logic [31:0]          beat_cnt_q, beat_cnt_d;

   logic                 beat;
   logic                 frame_end;
   logic [15:0]          frame_inc;
   logic                 trig_ok;
   logic                 wd_fire;

   assign beat      = s_tvalid_i & s_tready_i;
   assign frame_end = beat & s_tlast_i;
   assign frame_inc = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
   assign wd_fire   = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_W'(1));

`ifdef ADC_CAPTURE_EXT_TRIG_EN
   logic trig_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) trig_q <= 1'b0;
      else         trig_q <= trig_i;
   end

   assign trig_ok = trig_i & ~trig_q;
`else
   logic unused_trig;

   assign unused_trig = trig_i;
   assign trig_ok     = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      length_d     = length_q;
      num_frames_d = num_frames_q;
      gap_d        = gap_q;
      timeout_d    = timeout_q;
      aborted_d    = aborted_q;
      frame_cnt_d  = frame_cnt_q;
      beat_cnt_d   = (busy_q && beat) ? beat_cnt_q + 32'd1 : beat_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d      = ST_ARM;
               length_d     = frame_len_i;
               num_frames_d = num_frames_i;
               gap_d        = gap_cycles_i;
               frame_cnt_d  = 16'd0;
               beat_cnt_d   = 32'd0;
               timeout_d    = 1'b0;
               aborted_d    = 1'b0;
            end
         end
         ST_ARM: begin
            if (abort_i) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else begin
               state_d = ST_WAIT_TRIG;
            end
         end
         ST_WAIT_TRIG: begin
            if (abort_i) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else if (trig_ok) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            // A frame end coincident with abort is still counted; abort decides the next state.
            if (frame_end) frame_cnt_d = frame_inc;
            if (abort_i) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else if (frame_end) begin
               if ((num_frames_q != 16'd0) && (frame_inc == num_frames_q)) state_d = ST_DONE;
               else if (gap_q == '0)                                         state_d = ST_WAIT_TRIG;
               else                                                          state_d = ST_GAP;
            end else if (!beat && wd_fire) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (abort_i) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
               state_d = ST_WAIT_TRIG;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Down-counters reload whenever they are not actively running.
      gap_cnt_d    = (state_q == ST_GAP) ? gap_cnt_q - GAP_WIDTH'(1) : gap_q;
      wd_cnt_d     = (state_q == ST_CAPTURE && !beat) ? wd_cnt_q - WD_W'(1) : WD_LOAD;

      capture_en_d = (state_d == ST_CAPTURE);
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         length_q     <= 32'd0;
         num_frames_q <= 16'd0;
         gap_q        <= '0;
         gap_cnt_q    <= '0;
         wd_cnt_q     <= WD_LOAD;
         capture_en_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         aborted_q    <= 1'b0;
         frame_cnt_q  <= 16'd0;
         beat_cnt_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         length_q     <= length_d;
         num_frames_q <= num_frames_d;
         gap_q        <= gap_d;
         gap_cnt_q    <= gap_cnt_d;
         wd_cnt_q     <= wd_cnt_d;
         capture_en_q <= capture_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         aborted_q    <= aborted_d;
         frame_cnt_q  <= frame_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   assign capture_en_o = capture_en_q;
   assign length_o     = length_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign timeout_o    = timeout_q;
   assign aborted_o    = aborted_q;
   assign frame_cnt_o  = frame_cnt_q;
   assign beat_cnt_o   = beat_cnt_q;

endmodule
